arc4_crack: RTL and testbench

//  Initiator side of the arc4 en/rdy handshake: brute-force key search controller. For each

---
 rtl/crack_pkg.sv | 22 ++
 rtl/pt_scan.sv | 107 ++++++++++
 rtl/arc4_crack.sv | 113 +++++++++++
 tb/tb_arc4_crack.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// Shared types and helpers for the arc4 key-search controller and its plaintext scanner.
package crack_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_A_BUSY = 4'd2,
        ST_A_DONE = 4'd3,
        ST_RD_LEN = 4'd4,
        ST_RD_CHR = 4'd5,
        ST_CHK    = 4'd6,
        ST_NEXT   = 4'd7
    } state_t;

    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_MIN) && (b <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/pt_scan.sv
// Plaintext scanner: reads pt[0] as length, then streams pt[1..len] one byte per cycle
// and reports done+pass (pass = every byte printable, vacuously true for len=0).
module pt_scan
    import crack_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] pt_rddata_i,
    output logic [7:0] pt_addr_o,
    output logic       done_o,
    output logic       pass_o
);

    localparam logic [1:0] SC_IDLE  = 2'd0;
    localparam logic [1:0] SC_ADDR0 = 2'd1;
    localparam logic [1:0] SC_LEN   = 2'd2;
    localparam logic [1:0] SC_CHR   = 2'd3;

    logic [1:0] state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] len_q, len_d;
    logic [8:0] idx_q, idx_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [8:0] idx_plus2;

    assign idx_plus2 = idx_q + 9'd2;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        case (state_q)
            SC_IDLE: begin
                if (start_i) begin
                    addr_d  = 8'd0;
                    pass_d  = 1'b0;
                    state_d = SC_ADDR0;
                end
            end
            SC_ADDR0: begin
                // Address 1 is fetched speculatively while the length is still in flight.
                addr_d  = 8'd1;
                state_d = SC_LEN;
            end
            SC_LEN: begin
                len_d = pt_rddata_i;
                idx_d = 9'd1;
                if (pt_rddata_i == 8'd0) begin
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                    state_d = SC_IDLE;
                end else begin
                    if (pt_rddata_i >= 8'd2) begin
                        addr_d = 8'd2;
                    end
                    state_d = SC_CHR;
                end
            end
            SC_CHR: begin
                // Data on pt_rddata_i is pt[idx_q]; addr_q already points at idx_q+1.
                if (!is_printable(pt_rddata_i)) begin
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    state_d = SC_IDLE;
                end else if (idx_q == {1'b0, len_q}) begin
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                    state_d = SC_IDLE;
                end else begin
                    idx_d = idx_q + 9'd1;
                    if (idx_plus2 <= {1'b0, len_q}) begin
                        addr_d = idx_plus2[7:0];
                    end
                end
            end
            default: state_d = SC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SC_IDLE;
            addr_q  <= 8'd0;
            len_q   <= 8'd0;
            idx_q   <= 9'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign pt_addr_o = addr_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;

endmodule

// File: rtl/arc4_crack.sv
// Brute-force key search: drives one arc4 core per candidate key and stops on the first
// key whose plaintext is fully printable, or when the key space is exhausted.
module arc4_crack
    import crack_pkg::*;
#(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_STEP  = 24'h000001,
    parameter logic [23:0] KEY_MAX   = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    output logic        key_valid,
    output logic [23:0] key_out,
    output logic        arc4_en,
    input  logic        arc4_rdy,
    output logic [23:0] arc4_key,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata
);

    state_t      state_q, state_d;
    logic [23:0] cand_q, cand_d;
    logic [23:0] key_out_q, key_out_d;
    logic        key_valid_q, key_valid_d;
    logic        arc4_en_q, arc4_en_d;
    logic [24:0] sum;
    logic        scan_start, scan_done, scan_pass;

    // Carry bit catches wrap past 24'hFFFFFF.
    assign sum        = {1'b0, cand_q} + {1'b0, KEY_STEP};
    assign scan_start = (state_q == ST_RD_LEN);

    pt_scan u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (scan_start),
        .pt_rddata_i (pt_rddata),
        .pt_addr_o   (pt_addr),
        .done_o      (scan_done),
        .pass_o      (scan_pass)
    );

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        key_out_d   = key_out_q;
        key_valid_d = key_valid_q;
        arc4_en_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    key_valid_d = 1'b0;
                    cand_d      = KEY_START;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (arc4_rdy) begin
                    arc4_en_d = 1'b1;
                    state_d   = ST_A_BUSY;
                end
            end
            ST_A_BUSY: if (!arc4_rdy) state_d = ST_A_DONE;
            ST_A_DONE: if (arc4_rdy)  state_d = ST_RD_LEN;
            ST_RD_LEN: state_d = ST_RD_CHR;
            ST_RD_CHR: if (scan_done) state_d = ST_CHK;
            ST_CHK: begin
                if (scan_pass) begin
                    key_out_d   = cand_q;
                    key_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (sum[24] || (sum > {1'b0, KEY_MAX})) begin
                    key_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cand_d  = sum[23:0];
                    state_d = ST_START;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cand_q      <= KEY_START;
            key_out_q   <= 24'd0;
            key_valid_q <= 1'b0;
            arc4_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            key_out_q   <= key_out_d;
            key_valid_q <= key_valid_d;
            arc4_en_q   <= arc4_en_d;
        end
    end

    assign rdy       = (state_q == ST_IDLE);
    assign key_valid = key_valid_q;
    assign key_out   = key_out_q;
    assign arc4_en   = arc4_en_q;
    assign arc4_key  = cand_q;

endmodule

// File: tb/tb_arc4_crack.sv
// Bench for arc4_crack: two instances (step 1 and step 2) over a 16-key space, each with a
// behavioural arc4 core filling plaintext from a per-key table and a 1-cycle read RAM.
`timescale 1ns/1ps
module tb_arc4_crack;

    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en        [NI];
    logic        rdy       [NI];
    logic        key_valid [NI];
    logic [23:0] key_out   [NI];
    logic        arc4_en   [NI];
    logic        a_rdy     [NI];
    logic [23:0] arc4_key  [NI];
    logic [7:0]  pt_addr   [NI];
    logic [7:0]  pt_rddata [NI];

    logic [7:0]  pt_tab    [NI][16][256];
    logic [7:0]  mem       [NI][256];
    logic [23:0] lat_key   [NI];
    int          busy_cnt  [NI];
    int          nseen     [NI];
    logic [23:0] seen_keys [NI][64];
    int          hs_err    [NI];
    logic        prev_en   [NI];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] exp_keyout [NI];

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_inst
            arc4_crack #(
                .KEY_START (gi == 0 ? 24'h000000 : 24'h000001),
                .KEY_STEP  (gi == 0 ? 24'h000001 : 24'h000002),
                .KEY_MAX   (24'h00000F)
            ) dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (en[gi]),
                .rdy       (rdy[gi]),
                .key_valid (key_valid[gi]),
                .key_out   (key_out[gi]),
                .arc4_en   (arc4_en[gi]),
                .arc4_rdy  (a_rdy[gi]),
                .arc4_key  (arc4_key[gi]),
                .pt_addr   (pt_addr[gi]),
                .pt_rddata (pt_rddata[gi])
            );

            // arc4 model: busy for 5 cycles, then plaintext for the latched key appears.
            always @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rdy[gi]    <= 1'b1;
                    busy_cnt[gi] <= 0;
                end else if (a_rdy[gi] && arc4_en[gi]) begin
                    a_rdy[gi]    <= 1'b0;
                    busy_cnt[gi] <= 5;
                    lat_key[gi]  <= arc4_key[gi];
                end else if (!a_rdy[gi]) begin
                    if (busy_cnt[gi] == 1) begin
                        for (int j = 0; j < 256; j++)
                            mem[gi][j] <= pt_tab[gi][lat_key[gi][3:0]][j];
                        a_rdy[gi] <= 1'b1;
                    end
                    busy_cnt[gi] <= busy_cnt[gi] - 1;
                end
            end

            always @(posedge clk) pt_rddata[gi] <= mem[gi][pt_addr[gi]];

            // Handshake monitor: single-cycle start pulses, only to an idle core, key held while busy.
            always @(negedge clk) begin
                if (!rst_n) begin
                    prev_en[gi] = 1'b0;
                end else begin
                    if (arc4_en[gi] === 1'b1) begin
                        if (prev_en[gi] || !a_rdy[gi]) hs_err[gi] = hs_err[gi] + 1;
                        seen_keys[gi][nseen[gi] % 64] = arc4_key[gi];
                        nseen[gi] = nseen[gi] + 1;
                    end
                    if (!a_rdy[gi] && (arc4_key[gi] !== lat_key[gi])) hs_err[gi] = hs_err[gi] + 1;
                    prev_en[gi] = arc4_en[gi];
                end
            end
        end
    endgenerate

    function automatic int kstart(input int g);
        return (g == 0) ? 0 : 1;
    endfunction

    function automatic int kstep(input int g);
        return (g == 0) ? 1 : 2;
    endfunction

    function automatic bit all_print(input int g, input int k);
        int len;
        len = int'(pt_tab[g][k][0]);
        for (int j = 1; j <= len; j++)
            if (pt_tab[g][k][j] < 8'h20 || pt_tab[g][k][j] > 8'h7E) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: walk the key list in order, first fully printable message wins.
    task automatic ref_search(input int g, output bit found, output int fkey, output int runs);
        int k;
        k = kstart(g);
        found = 1'b0;
        fkey = 0;
        runs = 0;
        while (k <= 15) begin
            runs++;
            if (all_print(g, k)) begin
                found = 1'b1;
                fkey = k;
                return;
            end
            k += kstep(g);
        end
    endtask

    task automatic fill_filler(input int g);
        for (int k = 0; k < 16; k++) begin
            pt_tab[g][k][0] = 8'd2;
            pt_tab[g][k][1] = 8'h01;
            pt_tab[g][k][2] = 8'h01;
        end
    endtask

    task automatic set3(input int g, input int k, input logic [7:0] len,
                        input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        pt_tab[g][k][0] = len;
        pt_tab[g][k][1] = b1;
        pt_tab[g][k][2] = b2;
        pt_tab[g][k][3] = b3;
    endtask

    function automatic logic [7:0] rand_nonprint();
        int v;
        v = int'($urandom_range(0, 158));
        return (v < 32) ? 8'(v) : 8'(v + 95);
    endfunction

    task automatic fill_random(input int g);
        int len, bad, ak;
        for (int k = 0; k < 16; k++) begin
            len = int'($urandom_range(1, 12));
            pt_tab[g][k][0] = 8'(len);
            for (int j = 1; j <= len; j++) pt_tab[g][k][j] = 8'($urandom_range(32, 126));
            bad = int'($urandom_range(1, len));
            pt_tab[g][k][bad] = rand_nonprint();
        end
        if ($urandom_range(0, 3) != 0) begin
            ak = int'($urandom_range(0, 15));
            for (int j = 1; j <= int'(pt_tab[g][ak][0]); j++)
                pt_tab[g][ak][j] = 8'($urandom_range(32, 126));
        end
    endtask

    task automatic run_and_check(input int g, input bit poke, input string name);
        bit found, done;
        int fkey, runs, base, herr0, bad_seq;
        ref_search(g, found, fkey, runs);
        base  = nseen[g];
        herr0 = hs_err[g];
        @(negedge clk); en[g] = 1'b1;
        @(negedge clk); en[g] = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(negedge clk);
            en[g] = 1'b0;
            if (rdy[g]) begin
                done = 1'b1;
                break;
            end
            if (poke && (cyc % 5 == 2)) en[g] = 1'b1;
        end
        en[g] = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s.timeout: rdy=%0b after 8000 cycles, required 1", name, rdy[g]);
        end
        n_checks++;
        if ((nseen[g] - base) !== runs) begin
            n_fail++;
            $display("FAIL %s.runs: got %0d arc4 runs, required %0d", name, nseen[g] - base, runs);
        end
        bad_seq = 0;
        for (int r = 0; r < runs && r < (nseen[g] - base); r++)
            if (seen_keys[g][(base + r) % 64] !== 24'(kstart(g) + r * kstep(g))) bad_seq++;
        n_checks++;
        if (bad_seq != 0) begin
            n_fail++;
            $display("FAIL %s.key_seq: %0d candidate keys out of order, required 0", name, bad_seq);
        end
        n_checks++;
        if (key_valid[g] !== found) begin
            n_fail++;
            $display("FAIL %s.key_valid: got %0b, required %0b", name, key_valid[g], found);
        end
        if (found) exp_keyout[g] = 24'(fkey);
        n_checks++;
        if (key_out[g] !== exp_keyout[g]) begin
            n_fail++;
            $display("FAIL %s.key_out: got %06h, required %06h", name, key_out[g], exp_keyout[g]);
        end
        n_checks++;
        if (hs_err[g] !== herr0) begin
            n_fail++;
            $display("FAIL %s.handshake: %0d arc4 handshake violations, required 0", name, hs_err[g] - herr0);
        end
        $display("search %s inst%0d: runs=%0d key_valid=%0b key_out=%06h (model found=%0b key=%0d)",
                 name, g, nseen[g] - base, key_valid[g], key_out[g], found, fkey);
    endtask

    task automatic check_reset_vals(input string name);
        for (int g = 0; g < NI; g++) begin
            n_checks++;
            if (rdy[g] !== 1'b1 || key_valid[g] !== 1'b0 || key_out[g] !== 24'd0 ||
                arc4_en[g] !== 1'b0 || arc4_key[g] !== 24'(kstart(g)) || pt_addr[g] !== 8'd0) begin
                n_fail++;
                $display("FAIL %s.inst%0d: rdy=%0b kv=%0b ko=%06h en=%0b key=%06h addr=%02h, required 1 0 000000 0 %06h 00",
                         name, g, rdy[g], key_valid[g], key_out[g], arc4_en[g], arc4_key[g], pt_addr[g], kstart(g));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en[0] = 1'b0;
        en[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        $display("reset: values checked on both instances");
        rst_n = 1'b1;
        exp_keyout[0] = 24'd0;
        exp_keyout[1] = 24'd0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        fill_filler(0);
        set3(0, 3, 8'd2, "H", "I", 8'h01);
        run_and_check(0, 1'b1, "basic_en_ignored");
        fill_filler(0);
        run_and_check(0, 1'b0, "exhaust");
    endtask

    task automatic test_step();
        fill_filler(1);
        set3(1, 4, 8'd2, "H", "I", 8'h01);
        run_and_check(1, 1'b0, "step_even_answer");
        fill_filler(1);
        set3(1, 5, 8'd2, "H", "I", 8'h01);
        run_and_check(1, 1'b1, "step_odd_answer");
    endtask

    task automatic test_boundary();
        fill_filler(0);
        set3(0, 0, 8'd3, 8'h7E, 8'h20, 8'h1F);
        run_and_check(0, 1'b0, "reject_1f");
        set3(0, 0, 8'd3, 8'h7E, 8'h20, 8'h21);
        run_and_check(0, 1'b0, "accept_edges");
        set3(0, 0, 8'd0, 8'h01, 8'h01, 8'h01);
        run_and_check(0, 1'b0, "len_zero");
        fill_filler(0);
        pt_tab[0][9][0] = 8'd255;
        for (int j = 1; j <= 255; j++) pt_tab[0][9][j] = 8'($urandom_range(32, 126));
        pt_tab[0][9][255] = 8'h7F;
        run_and_check(0, 1'b0, "len255_last_bad");
        pt_tab[0][9][255] = 8'h7E;
        run_and_check(0, 1'b0, "len255_ok");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            fill_random(it % 2);
            run_and_check(it % 2, it[1], "random");
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit hit;
        fill_filler(0);
        fill_filler(1);
        base = nseen[0];
        @(negedge clk); en[0] = 1'b1;
        @(negedge clk); en[0] = 1'b0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if ((nseen[0] - base) >= 3 && !a_rdy[0]) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reset_mid.reach_busy: busy phase not seen within 1000 cycles, required seen");
        end
        #2 rst_n = 1'b0;
        #1 check_reset_vals("reset_mid_async");
        $display("reset_mid: asserted between edges, outputs checked");
        @(negedge clk);
        rst_n = 1'b1;
        exp_keyout[0] = 24'd0;
        exp_keyout[1] = 24'd0;
        set3(0, 2, 8'd2, "H", "I", 8'h01);
        run_and_check(0, 1'b0, "restart_after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_step();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
